// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator ALU sequencer.
// Holds the op codes, the ALU add/sub select values, the FSM states and the operand compare helper.
package calc_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAddSub,
        StMul,
        StDiv,
        StDone
    } calc_state_e;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
    } cmp_flags_t;

    function automatic cmp_flags_t compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return '{lt: (a < b), gt: (a > b), eq: (a == b)};
    endfunction

endpackage

// File: rtl/calc_iter_counter.sv
// Pass counter for the iterative MUL/DIV ops.
// It counts 0..Last and holds there; tc flags the final pass.
module calc_iter_counter
    import calc_pkg::*;
#(
    parameter int unsigned Last = WIDTH - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(Last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Sequencer for the shared 8-bit add/sub ALU: ADD/SUB in one pass, MUL (shift-add) and
// DIV (restoring) in WIDTH passes. ALU port drives are registered, so each op spends one load cycle.
module calc_alu_sequencer
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_add_sub,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_c8,
    input  logic             alu_alb,
    input  logic             alu_agb,
    input  logic             alu_aeb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    calc_state_e      state;
    logic             primed_q;
    logic             sub_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    cmp_flags_t       cmp_q;
    // MUL: hi/lo product halves. DIV: hi = partial remainder, lo = shifting quotient.
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;

    logic             cnt_load;
    logic             cnt_en;
    logic             last_pass;

    logic [WIDTH:0]   mul_acc;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic             div_fits;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] div_q;

    logic             finish;
    logic [WIDTH-1:0] fin_result;
    logic [WIDTH-1:0] fin_remainder;
    logic             fin_carry;
    logic             fin_negative;
    logic             fin_overflow;
    logic             fin_dbz;

    assign cnt_load = (state == StIdle) && start;
    assign cnt_en   = primed_q && ((state == StMul) || (state == StDiv));

    calc_iter_counter #(
        .Last (WIDTH - 1)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .tc   (last_pass)
    );

    always_comb begin
        mul_acc     = acc_lo_q[0] ? {alu_c8, alu_sum} : {1'b0, acc_hi_q};
        mul_hi_next = mul_acc[WIDTH:1];
        mul_lo_next = {mul_acc[0], acc_lo_q[WIDTH-1:1]};
        div_fits    = alu_agb | alu_aeb;
        div_r       = div_fits ? alu_sum : acc_hi_q;
        div_q       = {acc_lo_q[WIDTH-1:1], div_fits};
    end

    always_comb begin
        finish        = 1'b0;
        fin_result    = '0;
        fin_remainder = '0;
        fin_carry     = 1'b0;
        fin_negative  = 1'b0;
        fin_overflow  = 1'b0;
        fin_dbz       = 1'b0;
        case (state)
            StAddSub: begin
                if (primed_q) begin
                    finish       = 1'b1;
                    fin_result   = alu_sum;
                    fin_carry    = alu_c8;
                    fin_negative = sub_q & alu_alb;
                end
            end
            StMul: begin
                if (primed_q && last_pass) begin
                    finish       = 1'b1;
                    fin_result   = mul_lo_next;
                    fin_overflow = |mul_hi_next;
                end
            end
            StDiv: begin
                // Divide-by-zero uses its load cycle to finish; the ALU is never driven.
                if (!primed_q && (opb_q == '0)) begin
                    finish        = 1'b1;
                    fin_result    = '1;
                    fin_remainder = opa_q;
                    fin_dbz       = 1'b1;
                end else if (primed_q && last_pass) begin
                    finish        = 1'b1;
                    fin_result    = div_q;
                    fin_remainder = div_r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            primed_q    <= 1'b0;
            sub_q       <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmp_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_add_sub <= ALU_ADD;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            carry       <= 1'b0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            lt          <= 1'b0;
            gt          <= 1'b0;
            eq          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (finish) begin
                state       <= StDone;
                busy        <= 1'b0;
                done        <= 1'b1;
                result      <= fin_result;
                remainder   <= fin_remainder;
                carry       <= fin_carry;
                negative    <= fin_negative;
                overflow    <= fin_overflow;
                div_by_zero <= fin_dbz;
                lt          <= cmp_q.lt;
                gt          <= cmp_q.gt;
                eq          <= cmp_q.eq;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            busy     <= 1'b1;
                            primed_q <= 1'b0;
                            sub_q    <= op[0];
                            opa_q    <= opa;
                            opb_q    <= opb;
                            cmp_q    <= compare(opa, opb);
                            if (op == OP_DIV) begin
                                // Pre-apply the first {R,Q} left shift.
                                acc_hi_q <= {{(WIDTH-1){1'b0}}, opa[WIDTH-1]};
                                acc_lo_q <= {opa[WIDTH-2:0], 1'b0};
                                state    <= StDiv;
                            end else if (op == OP_MUL) begin
                                acc_hi_q <= '0;
                                acc_lo_q <= opb;
                                state    <= StMul;
                            end else begin
                                state <= StAddSub;
                            end
                        end
                    end
                    StAddSub: begin
                        alu_a       <= opa_q;
                        alu_b       <= opb_q;
                        alu_add_sub <= sub_q;
                        primed_q    <= 1'b1;
                    end
                    StMul: begin
                        if (!primed_q) begin
                            alu_a       <= acc_hi_q;
                            alu_b       <= opa_q;
                            alu_add_sub <= ALU_ADD;
                            primed_q    <= 1'b1;
                        end else begin
                            acc_hi_q <= mul_hi_next;
                            acc_lo_q <= mul_lo_next;
                            alu_a    <= mul_hi_next;
                        end
                    end
                    StDiv: begin
                        if (!primed_q) begin
                            alu_a       <= acc_hi_q;
                            alu_b       <= opb_q;
                            alu_add_sub <= ALU_SUB;
                            primed_q    <= 1'b1;
                        end else begin
                            // Remainder stays below 128 here, so the shift cannot lose a bit.
                            acc_hi_q <= {div_r[WIDTH-2:0], div_q[WIDTH-1]};
                            acc_lo_q <= {div_q[WIDTH-2:0], 1'b0};
                            alu_a    <= {div_r[WIDTH-2:0], div_q[WIDTH-1]};
                        end
                    end
                    StDone: state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Bench for calc_alu_sequencer: behavioural 8-bit ALU plus an arithmetic reference model
// for results, flags and latency, driven with directed and random operations.
module tb_calc_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] opa = 8'h00;
    logic [7:0] opb = 8'h00;
    logic [7:0] alu_a, alu_b, alu_sum;
    logic       alu_add_sub, alu_c8, alu_alb, alu_agb, alu_aeb;
    logic       busy, done, carry, negative, overflow, div_by_zero, lt, gt, eq;
    logic [7:0] result, remainder;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External ALU: A+B or A+~B+1, with magnitude compare of its inputs.
    logic [8:0] alu_full;
    always_comb begin
        if (alu_add_sub) alu_full = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        else             alu_full = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_sum = alu_full[7:0];
    assign alu_c8  = alu_full[8];
    assign alu_alb = (alu_a < alu_b);
    assign alu_agb = (alu_a > alu_b);
    assign alu_aeb = (alu_a == alu_b);

    calc_alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_add_sub (alu_add_sub),
        .alu_sum     (alu_sum),
        .alu_c8      (alu_c8),
        .alu_alb     (alu_alb),
        .alu_agb     (alu_agb),
        .alu_aeb     (alu_aeb),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .remainder   (remainder),
        .carry       (carry),
        .negative    (negative),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .lt          (lt),
        .gt          (gt),
        .eq          (eq)
    );

    // flags = {carry, negative, overflow, div_by_zero, lt, gt, eq}
    function automatic void ref_calc(input logic [1:0] o, input int a, input int b,
                                     output logic [7:0] r, output logic [7:0] rm,
                                     output logic [6:0] fl, output int lat);
        int  full;
        bit  c, n, v, z;
        c = 0; n = 0; v = 0; z = 0; rm = 8'h00;
        case (o)
            2'd0: begin full = a + b; r = 8'(full); c = (full > 255); lat = 2; end
            2'd1: begin full = a - b; r = 8'(full); c = (a >= b); n = (a < b); lat = 2; end
            2'd2: begin full = a * b; r = 8'(full); v = (full > 255); lat = 9; end
            default: begin
                if (b == 0) begin r = 8'hFF; rm = 8'(a); z = 1; lat = 1; end
                else begin r = 8'(a / b); rm = 8'(a % b); lat = 9; end
            end
        endcase
        fl = {c, n, v, z, (a < b), (a > b), (a == b)};
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] a,
                          input logic [7:0] b);
        logic [7:0] er, erm;
        logic [6:0] efl;
        int         elat, lat;
        bit         busy_ok;
        ref_calc(o, int'(a), int'(b), er, erm, efl, elat);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 0;
        end
        n_cmp++;
        if (lat !== elat) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        n_cmp++;
        if (busy_ok !== 1'b1) begin
            n_err++; $display("FAIL %s busy_window: got busy low early, want high until done", name);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        n_cmp++;
        if (result !== er) begin
            n_err++; $display("FAIL %s result: got %h want %h", name, result, er);
        end
        n_cmp++;
        if (remainder !== erm) begin
            n_err++; $display("FAIL %s remainder: got %h want %h", name, remainder, erm);
        end
        n_cmp++;
        if ({carry, negative, overflow, div_by_zero, lt, gt, eq} !== efl) begin
            n_err++;
            $display("FAIL %s flags(c,n,v,z,lt,gt,eq): got %b want %b", name,
                     {carry, negative, overflow, div_by_zero, lt, gt, eq}, efl);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL %s done_pulse: got %b want 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result, remainder, carry, negative, overflow, div_by_zero, lt, gt, eq,
             alu_a, alu_b, alu_add_sub} !== 44'd0) begin
            n_err++; $display("FAIL reset_state: got nonzero outputs (result %h) want all 0", result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL idle_after_reset: got busy/done %b want 00", {busy, done});
        end
    endtask

    task automatic test_addsub();
        run_op("add_200_100", 2'd0, 8'd200, 8'd100);
        run_op("sub_5_9", 2'd1, 8'd5, 8'd9);
        run_op("sub_9_9", 2'd1, 8'd9, 8'd9);
        run_op("add_0_0", 2'd0, 8'd0, 8'd0);
    endtask

    task automatic test_mul();
        run_op("mul_13_11", 2'd2, 8'd13, 8'd11);
        run_op("mul_16_16", 2'd2, 8'd16, 8'd16);
        run_op("mul_255_255", 2'd2, 8'd255, 8'd255);
    endtask

    task automatic test_div();
        run_op("div_200_7", 2'd3, 8'd200, 8'd7);
        run_op("div_255_200", 2'd3, 8'd255, 8'd200);
        run_op("div_42_0", 2'd3, 8'd42, 8'd0);
        run_op("div_3_250", 2'd3, 8'd3, 8'd250);
    endtask

    task automatic test_start_ignored();
        logic [7:0] er, erm;
        logic [6:0] efl;
        int         elat, lat;
        ref_calc(2'd2, 37, 7, er, erm, efl, elat);
        @(negedge clk);
        op = 2'd2; opa = 8'd37; opb = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        op = 2'd0; opa = 8'd1; opb = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== elat) begin
            n_err++; $display("FAIL busy_start latency: got %0d want %0d", lat, elat);
        end
        n_cmp++;
        if ({result, overflow} !== {er, efl[4]}) begin
            n_err++; $display("FAIL busy_start result/ovf: got %h/%b want %h/%b", result, overflow,
                              er, efl[4]);
        end
        // Start during the DONE cycle must not launch anything.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_err++; $display("FAIL done_cycle_start: got busy/done %b want 00", {busy, done});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = 2'd2; opa = 8'd200; opb = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, result, remainder, carry, negative, overflow, div_by_zero, lt, gt, eq,
             alu_a} !== 37'd0) begin
            n_err++; $display("FAIL reset_mid: got busy %b result %h alu_a %h want all 0", busy,
                              result, alu_a);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_done: got %b want 0", done);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op("mul_3_3_after_rst", 2'd2, 8'd3, 8'd3);
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [7:0] a, b;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'd0;
            if ($urandom_range(0, 7) == 0) a = 8'd255;
            run_op("random", o, a, b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
